dmem_responder: RTL and testbench

Data-memory responder that serves the load/store unit's memory requests. It sits between the LSU's dmem-side outputs (address, store data, byte mask) and an internal word-addressed storage array. Requests arrive over a valid/ready channel and are applied with per-byte write enables. Every accepted request returns exactly one response through a 2-entry response queue, so the response channel can be back-pressured without losing data.

---
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a valid/ready request
// channel. Stores use per-byte enables, loads return the full word. Every
// accepted request produces one response through a 2-entry FIFO, so the
// response side can stall without losing data.
//
// Optional feature: define DMEM_RANGE_CHECK_EN to flag word indices >= DEPTH
// as errors (store suppressed, rdata = 0, err = 1). Without it the index
// wraps modulo DEPTH and rsp_err is tied low.
module dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  localparam int MASK_SIZE = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [MASK_SIZE-1:0]  req_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  // Word storage; intentionally not reset
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      idx;
  logic                  oor;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;

  // Response queue state
  logic [DATA_WIDTH-1:0] q_data [2];
  logic [1:0]            q_err;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  // Byte-offset bits and (when wrapping) the high index bits carry no meaning
  logic unused_addr;
  assign unused_addr = ^req_addr;

  // Low index bits select the word; upper bits alias unless range-checked
  assign idx = req_addr[IDX_W+1:2];

`ifdef DMEM_RANGE_CHECK_EN
  generate
    if (ADDR_WIDTH - 2 > IDX_W) begin : g_range
      assign oor = |req_addr[ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_no_range
      assign oor = 1'b0;
    end
  endgenerate
`else
  assign oor = 1'b0;
`endif

  assign req_ready = (count < 2'd2);
  assign rsp_valid = (count != 2'd0);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Read combinationally so the response is captured on the accepting edge
  assign push_data = (req_we || oor) ? '0 : mem[idx];

  assign rsp_rdata = q_data[rd_ptr];
  assign rsp_err   = q_err[rd_ptr];

  // Byte-masked store; gated by rst_n so nothing is written during reset
  always_ff @(posedge clk) begin
    if (rst_n && push && req_we && !oor) begin
      for (int i = 0; i < MASK_SIZE; i++) begin
        if (req_mask[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response FIFO: push on accept, pop on handshake, count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      q_data[0] <= '0;
      q_data[1] <= '0;
      q_err     <= 2'b00;
    end else begin
      if (push) begin
        q_data[wr_ptr] <= push_data;
        q_err[wr_ptr]  <= oor;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder. A behavioural model
// (word map + response queue) predicts every handshake and response.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_mask  (req_mask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  logic [31:0] mem_m [longint];
  rsp_t        exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pf(input int k);
    return 32'hA5A5_0000 + 32'(k) * 32'h0001_0203;
  endfunction

  // One clock: check outputs against the model, drive inputs, update model.
  task automatic cycle(input bit v, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, input bit rr);
    bit          acc;
    bit          pp;
    bit          oor;
    longint      widx;
    logic [31:0] w;
    rsp_t        r;
    @(negedge clk);
    check("req_ready", req_ready, exp_q.size() < 2);
    check("rsp_valid", rsp_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("rsp_rdata", rsp_rdata, exp_q[0].d);
      check("rsp_err", rsp_err, exp_q[0].e);
    end
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_mask = m;
    rsp_ready = rr;
    acc = v && (exp_q.size() < 2);
    pp  = (exp_q.size() != 0) && rr;
    @(posedge clk);
    if (pp) void'(exp_q.pop_front());
    if (acc) begin
      widx = longint'(a >> 2);
      oor  = RANGE_CHECK && (widx >= DEPTH);
      if (!RANGE_CHECK) widx = widx % DEPTH;
      r.e = oor;
      r.d = 32'h0;
      if (we) begin
        if (!oor) begin
          w = mem_m.exists(widx) ? mem_m[widx] : 32'h0;
          for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
          mem_m[widx] = w;
        end
      end else if (!oor) begin
        r.d = mem_m[widx];
      end
      exp_q.push_back(r);
      $display("[TB] accept %s addr=%h wdata=%h mask=%b -> rdata=%h err=%0d",
               we ? "st" : "ld", a, d, m, r.d, r.e);
    end
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] d, input logic e);
    @(negedge clk);
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_rdata"}, rsp_rdata, d);
    check({tag, "_err"}, rsp_err, e);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_mask = '0;
    rsp_ready = 1'b0;
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_ready", req_ready, 1);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Prefill words 0..15
    for (int k = 0; k < 16; k++) cycle(1, 1, 32'(k * 4), pf(k), 4'hF, 1);
    drain(2);

    // Full-word store then load, then partial-lane store
    cycle(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    expect_head("st_rsp", 32'h0, 1'b0);
    cycle(1, 0, 32'h10, 0, 0, 1);
    expect_head("ld_full", 32'hDEADBEEF, 1'b0);
    cycle(1, 1, 32'h11, 32'h0000AB00, 4'b0010, 1);
    cycle(1, 0, 32'h10, 0, 0, 1);
    expect_head("ld_merge", 32'hDEADABEF, 1'b0);
    // Zero-mask store still answers and writes nothing
    cycle(1, 1, 32'h14, 32'hFFFFFFFF, 4'h0, 1);
    cycle(1, 0, 32'h14, 0, 0, 1);
    drain(2);

    // Back-pressure: A, B accepted, C held off
    cycle(1, 0, 32'h20, 0, 0, 0);
    cycle(1, 0, 32'h24, 0, 0, 0);
    cycle(1, 0, 32'h28, 0, 0, 0);
    expect_head("full_head", pf(8), 1'b0);
    @(negedge clk);
    check("full_ready", req_ready, 0);
    check("full_hold", rsp_rdata, pf(8));
    cycle(1, 0, 32'h28, 0, 0, 1);
    cycle(1, 0, 32'h28, 0, 0, 1);
    drain(3);

    // Streaming loads at full rate
    for (int k = 0; k < 8; k++) cycle(1, 0, 32'(k * 4), 0, 0, 1);
    drain(2);

    // Out-of-range / aliasing store at word 1024
    cycle(1, 1, 32'h1000, 32'h12345678, 4'hF, 0);
    expect_head("oor_st", 32'h0, RANGE_CHECK);
    cycle(1, 0, 32'h0, 0, 0, 1);
    expect_head("alias_ld", RANGE_CHECK ? pf(0) : 32'h12345678, 1'b0);
    drain(2);

    // Reset with a full queue; a store presented during reset is dropped
    cycle(1, 0, 32'h4, 0, 0, 0);
    cycle(1, 0, 32'h8, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hC; req_wdata = 32'hBAD0BAD0;
    req_mask = 4'hF;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_ready", req_ready, 1);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b0;
    cycle(1, 0, 32'hC, 0, 0, 0);
    expect_head("post_rst", pf(3), 1'b0);
    drain(2);

    // Random traffic over words 0..15 and their aliases above DEPTH
    for (int n = 0; n < 300; n++) begin
      int          k;
      logic [31:0] a;
      k = int'($urandom_range(0, 15));
      a = ($urandom_range(0, 7) == 0) ? 32'((DEPTH + k) * 4) : 32'(k * 4);
      a = a | 32'($urandom_range(0, 3));
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, a,
            $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    drain(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
